// File: rtl/fsub_issue_ctrl.sv
// fsub_issue_ctrl: credit-based issue/collect wrapper around the stall-free 2-stage fsub datapath.
module fsub_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fsub_x1,
  output logic [31:0]      fsub_x2,
  input  logic [31:0]      fsub_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  logic [LAT:0]       r_vpipe;
  logic [TAG_W-1:0]   r_tpipe [LAT+1];
  logic [AW:0]        r_count;
  logic [AW-1:0]      r_wp, r_rp;
  logic [31:0]        r_mem_y [DEPTH];
  logic [TAG_W-1:0]   r_mem_t [DEPTH];
  logic               w_acc, w_push, w_pop;
  // Credits count every op still inside fsub, including the one pushing this cycle.
  assign in_ready  = !rst && (int'(r_count) + $countones(r_vpipe) < DEPTH);
  assign w_acc     = in_valid && in_ready;
  assign w_push    = r_vpipe[LAT];
  assign out_valid = r_count != '0;
  assign w_pop     = out_valid && out_ready;
  assign out_y     = out_valid ? r_mem_y[r_rp] : '0;
  assign out_tag   = out_valid ? r_mem_t[r_rp] : '0;
  assign busy      = |r_vpipe || out_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsub_x1 <= '0;
      fsub_x2 <= '0;
      r_vpipe <= '0;
      for (int i = 0; i <= LAT; i++) r_tpipe[i] <= '0;
      r_count <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      if (w_acc) begin
        fsub_x1 <= in_x1;
        fsub_x2 <= in_op ? {~in_x2[31], in_x2[30:0]} : in_x2;
      end
      r_vpipe    <= {r_vpipe[LAT-1:0], w_acc};
      r_tpipe[0] <= in_tag;
      for (int i = 1; i <= LAT; i++) r_tpipe[i] <= r_tpipe[i-1];
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_y[r_wp] <= fsub_y;
      r_mem_t[r_wp] <= r_tpipe[LAT];
    end
  end
  always @(posedge clk) begin
    if (!rst) assert (!(w_push && int'(r_count) == DEPTH)) else $error("push into full FIFO");
  end
endmodule

// File: tb/tb_fsub_issue_ctrl.sv
// tb_fsub_issue_ctrl: vector table plus directed sequences against a 2-stage fsub stand-in.
module tb_fsub_issue_ctrl;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_op = 0, out_ready = 0;
  logic [31:0] in_x1 = 0, in_x2 = 0;
  logic [3:0]  in_tag = 0;
  logic        in_ready, out_valid, busy;
  logic [31:0] fsub_x1, fsub_x2, fsub_y, out_y, r_s1;
  logic [3:0]  out_tag;
  int n_tests = 0, n_fail = 0;

  fsub_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag), .fsub_x1(fsub_x1), .fsub_x2(fsub_x2),
    .fsub_y(fsub_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact differences for the operand pairs used in the table, a cheap mix elsewhere.
  function automatic logic [31:0] f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h3F000000) return 32'h3F800000;
    if (a == 32'h3F800000 && b == 32'hBF800000) return 32'h40000000;
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'hC0000000) return 32'h40800000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  always_ff @(posedge clk) begin
    r_s1   <= f(fsub_x1, fsub_x2);
    fsub_y <= r_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] feed(input logic op, input logic [31:0] x2);
    return op ? {~x2[31], x2[30:0]} : x2;
  endfunction

  typedef struct {
    logic        op;
    logic [31:0] x1, x2;
    logic [3:0]  tag;
    logic [31:0] ex2, ey;
  } vec_t;

  vec_t vt[4];
  logic [31:0] ty[20];
  logic [31:0] tx1[20], tx2[20];
  logic        top[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    bit saw;
    vt[0] = '{1'b0, 32'h3FC00000, 32'h3F000000, 4'd5,  32'h3F000000, 32'h3F800000};
    vt[1] = '{1'b1, 32'h3F800000, 32'h3F800000, 4'd9,  32'hBF800000, 32'h40000000};
    vt[2] = '{1'b0, 32'h40400000, 32'h3F800000, 4'd3,  32'h3F800000, 32'h40000000};
    vt[3] = '{1'b1, 32'h40000000, 32'h40000000, 4'd15, 32'hC0000000, 32'h40800000};

    #3;
    chk("rst_outs", 64'({in_ready, out_valid, busy, out_y, out_tag}), 64'd0);
    chk("rst_ops", {fsub_x1, fsub_x2}, 64'd0);
    tick();
    rst = 0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    out_ready = 1;
    foreach (vt[k]) begin
      tick();
      in_valid = 1; in_op = vt[k].op; in_x1 = vt[k].x1; in_x2 = vt[k].x2; in_tag = vt[k].tag;
      chk("vec_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 0;
      chk("vec_fsub_x", {fsub_x1, fsub_x2}, {vt[k].x1, vt[k].ex2});
      tick(); tick();
      chk("vec_early", 64'(out_valid), 64'd0);
      tick();
      chk("vec_out", 64'({out_valid, out_tag, out_y}), 64'({1'b1, vt[k].tag, vt[k].ey}));
      tick();
      chk("vec_idle", 64'({busy, out_valid}), 64'd0);
    end

    for (int i = 0; i < 20; i++) begin
      top[i] = i[0];
      tx1[i] = 32'h40000000 + 32'(i);
      tx2[i] = 32'h3F000000 + 32'(i * 3);
      ty[i]  = f(tx1[i], feed(top[i], tx2[i]));
    end
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        in_valid = 1; in_op = top[c]; in_x1 = tx1[c]; in_x2 = tx2[c]; in_tag = 4'(c);
        chk("tp_ready", 64'(in_ready), 64'd1);
      end else in_valid = 0;
      if (c >= 4 && c < 24)
        chk("tp_out", 64'({out_valid, out_tag, out_y}), 64'({1'b1, 4'(c - 4), ty[c-4]}));
      else
        chk("tp_gap", 64'(out_valid), 64'd0);
      tick();
    end
    chk("tp_idle", 64'(busy), 64'd0);

    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid = 1; in_op = 0; in_x1 = 32'h41000000 + 32'(acc); in_x2 = 0; in_tag = 4'(acc);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    chk("bp_accepts", 64'(acc), 64'd8);
    chk("bp_full", 64'({in_ready, out_valid, busy}), 64'b011);
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain", 64'({out_valid, out_tag, out_y}), 64'({1'b1, 4'(k), 32'h41000000 + 32'(k)}));
      if (k == 0) chk("bp_ready_hold", 64'(in_ready), 64'd0);
      if (k == 1) chk("bp_ready_back", 64'(in_ready), 64'd1);
      tick();
    end
    chk("bp_empty", 64'({out_valid, busy}), 64'd0);

    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_op = 0; in_x1 = 32'h42000000 + 32'(c); in_x2 = 32'h1; in_tag = 4'(c + 1);
      tick();
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst", 64'({out_valid, busy, in_ready}), 64'd0);
    chk("mid_rst_ops", {fsub_x1, fsub_x2}, 64'd0);
    #2 rst = 0;
    saw = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid || busy) saw = 1;
    end
    chk("no_stale", 64'(saw), 64'd0);
    in_valid = 1; in_op = 0; in_x1 = 32'h3FC00000; in_x2 = 32'h3F000000; in_tag = 4'd12;
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    chk("post_rst_req", 64'({out_valid, out_tag, out_y}), 64'({1'b1, 4'd12, 32'h3F800000}));
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
